systolic_layer_sched: RTL and testbench

Layer-level sequencer for the systolic convolution datapath (weight cache, Img2Col stream, PE array). Splits the output-channel dimension into column tiles of ARRAY_COLS and handles each tile in turn:
- commands a weight-cache load and waits for the cached handshake;
- starts the Img2Col stream and counts accepted output beats.
After the final tile it flags the last beat and pulses done. Sits between the host/DMA control registers and the weight-cache/Img2Col start inputs.

---
 rtl/systolic_layer_sched.sv | 246 ++++++++++++++++++++++++
 tb/tb_systolic_layer_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_layer_sched.sv
// ---------------------------------------------------------------------------
// systolic_layer_sched
//
// Layer-level sequencer for the systolic convolution datapath. The output
// channel dimension is split into column tiles of ARRAY_COLS. For each tile
// the block asks the weight cache for a load, waits for the tile to be
// resident, kicks the Img2Col stream and counts accepted output beats. After
// the final beat of the final tile it flags out_last and pulses done.
//
// Optional build macro:
//   SCHED_PERF_CNT_EN - adds perf_busy_cycles / perf_stall_cycles counters.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   start, abort        launch pulse (idle only), synchronous layer abort
//   cfg_matrix_row/col  weight matrix rows (K*K*Cin) and output channels
//   cfg_out_rows        output beats per tile (OH*OW)
//   wgt_start           one-cycle weight tile load request
//   wgt_col_base        first output channel of the current tile
//   wgt_tile_cols       valid columns in the current tile
//   wgt_matrix_row      latched cfg_matrix_row
//   wgt_cached          weight tile resident (level)
//   img_start           one-cycle Img2Col stream start
//   out_valid/out_ready array output handshake (observed only)
//   tile_last/out_last  accepted beat closes the tile / the layer
//   tile_idx            current tile number
//   busy, done          activity level, one-cycle completion pulse
//   cfg_err             sticky bad-configuration flag
//   perf_*              (SCHED_PERF_CNT_EN) busy and stall cycle counters
// ---------------------------------------------------------------------------
module systolic_layer_sched #(
    parameter int ARRAY_COLS = 8,
    parameter int ROW_W      = 16,
    parameter int CNT_W      = 32,
    parameter int TILE_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ROW_W-1:0]  cfg_matrix_row,
    input  logic [ROW_W-1:0]  cfg_matrix_col,
    input  logic [CNT_W-1:0]  cfg_out_rows,
    output logic              wgt_start,
    output logic [ROW_W-1:0]  wgt_col_base,
    output logic [ROW_W-1:0]  wgt_tile_cols,
    output logic [ROW_W-1:0]  wgt_matrix_row,
    input  logic              wgt_cached,
    output logic              img_start,
    input  logic              out_valid,
    input  logic              out_ready,
    output logic              tile_last,
    output logic              out_last,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_stall_cycles
`endif
);

    // state   | meaning
    // --------+-----------------------------------------------------
    // IDLE    | waiting for start
    // WSTART  | weight tile load request (wgt_start pulse)
    // WWAIT   | waiting for wgt_cached
    // ISTART  | Img2Col start pulse, beat counter cleared
    // STREAM  | counting accepted output beats of the current tile
    // DONE    | completion pulse, back to IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_WSTART, S_WWAIT, S_ISTART, S_STREAM, S_DONE
    } state_t;

    localparam int NT_W = ROW_W + 1;
    localparam int unsigned MAX_TILES = 2 ** TILE_W;

    state_t state_q, state_d;

    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  rows_q, rows_d;
    logic [NT_W-1:0]   num_tiles_q, num_tiles_d;
    logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
    logic [ROW_W-1:0]  col_base_q, col_base_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              cfg_err_q, cfg_err_d;

    logic              start_acc;
    logic              abort_act;
    logic [NT_W-1:0]   num_tiles_in;
    logic              cfg_bad;
    logic              beat;
    logic              tile_end;
    logic              layer_end;
    logic [ROW_W-1:0]  col_rem;

    assign start_acc    = (state_q == S_IDLE) && start && !abort;
    assign abort_act    = abort && (state_q != S_IDLE);
    assign num_tiles_in = (NT_W'(cfg_matrix_col) + NT_W'(ARRAY_COLS - 1)) / NT_W'(ARRAY_COLS);
    assign cfg_bad      = (cfg_matrix_row == '0) || (cfg_matrix_col == '0) ||
                          (cfg_out_rows == '0) || (32'(num_tiles_in) > MAX_TILES);
    assign beat         = out_valid && out_ready;

    // Abort suppresses the tile/layer end flags of a same-cycle final beat.
    assign tile_end  = (state_q == S_STREAM) && beat && !abort &&
                       (beat_cnt_q == rows_q - CNT_W'(1));
    assign layer_end = tile_end && (NT_W'(tile_idx_q) == num_tiles_q - NT_W'(1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rows_q      <= '0;
            num_tiles_q <= '0;
            tile_idx_q  <= '0;
            col_base_q  <= '0;
            beat_cnt_q  <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rows_q      <= rows_d;
            num_tiles_q <= num_tiles_d;
            tile_idx_q  <= tile_idx_d;
            col_base_q  <= col_base_d;
            beat_cnt_q  <= beat_cnt_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_acc) state_d = cfg_bad ? S_DONE : S_WSTART;
            S_WSTART: state_d = S_WWAIT;
            S_WWAIT:  if (wgt_cached) state_d = S_ISTART;
            S_ISTART: state_d = S_STREAM;
            S_STREAM: if (tile_end) state_d = layer_end ? S_DONE : S_WSTART;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort_act) state_d = S_IDLE;
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        rows_d      = rows_q;
        num_tiles_d = num_tiles_q;
        tile_idx_d  = tile_idx_q;
        col_base_d  = col_base_q;
        beat_cnt_d  = beat_cnt_q;
        cfg_err_d   = cfg_err_q;

        if (start_acc) begin
            row_d       = cfg_matrix_row;
            col_d       = cfg_matrix_col;
            rows_d      = cfg_out_rows;
            num_tiles_d = num_tiles_in;
            tile_idx_d  = '0;
            col_base_d  = '0;
            beat_cnt_d  = '0;
            cfg_err_d   = cfg_bad;
        end else if (abort_act) begin
            tile_idx_d = '0;
            col_base_d = '0;
            beat_cnt_d = '0;
        end else if (state_q == S_ISTART) begin
            beat_cnt_d = '0;
        end else if (state_q == S_STREAM && beat) begin
            if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (tile_end && !layer_end) begin
                tile_idx_d = tile_idx_q + TILE_W'(1);
                col_base_d = col_base_q + ROW_W'(ARRAY_COLS);
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        wgt_start = 1'b0;
        img_start = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        tile_last = tile_end;
        out_last  = layer_end;
        case (state_q)
            S_WSTART: begin wgt_start = !abort; busy = 1'b1; end
            S_WWAIT:  busy = 1'b1;
            S_ISTART: begin img_start = !abort; busy = 1'b1; end
            S_STREAM: busy = 1'b1;
            S_DONE:   done = !abort;
            default:  ;
        endcase
    end

    assign col_rem        = col_q - col_base_q;
    assign wgt_tile_cols  = (col_rem > ROW_W'(ARRAY_COLS)) ? ROW_W'(ARRAY_COLS) : col_rem;
    assign wgt_col_base   = col_base_q;
    assign wgt_matrix_row = row_q;
    assign tile_idx       = tile_idx_q;
    assign cfg_err        = cfg_err_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall;

    assign stall = (state_q == S_WWAIT) ||
                   ((state_q == S_STREAM) && out_valid && !out_ready);

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (start_acc) begin
            perf_busy_d  = '0;
            perf_stall_d = '0;
        end else begin
            if (busy && perf_busy_q != '1)   perf_busy_d  = perf_busy_q + 32'd1;
            if (stall && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_systolic_layer_sched.sv
module tb_systolic_layer_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [15:0] cfg_matrix_row, cfg_matrix_col;
    logic [31:0] cfg_out_rows;
    logic        wgt_start;
    logic [15:0] wgt_col_base, wgt_tile_cols, wgt_matrix_row;
    logic        wgt_cached;
    logic        img_start;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        tile_last, out_last;
    logic [7:0]  tile_idx;
    logic        busy, done, cfg_err;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

    systolic_layer_sched dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_matrix_row(cfg_matrix_row), .cfg_matrix_col(cfg_matrix_col),
        .cfg_out_rows(cfg_out_rows),
        .wgt_start(wgt_start), .wgt_col_base(wgt_col_base),
        .wgt_tile_cols(wgt_tile_cols), .wgt_matrix_row(wgt_matrix_row),
        .wgt_cached(wgt_cached), .img_start(img_start),
        .out_valid(out_valid), .out_ready(out_ready),
        .tile_last(tile_last), .out_last(out_last), .tile_idx(tile_idx),
        .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef SCHED_PERF_CNT_EN
        , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] base; logic [15:0] cols; logic [7:0] tidx; logic [15:0] row;} wexp_t;
    typedef struct {logic tl; logic ol; logic endf;} bexp_t;

    wexp_t wq[$];
    bexp_t bq[$];
    logic  dq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_ol_cyc = 0;
    logic in_stream = 1'b0;
    logic ready_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // downstream ready: constant 1 or toggling every cycle
    always @(posedge clk) begin
        #1;
        if (ready_mode) out_ready = ~out_ready;
        else            out_ready = 1'b1;
    end

    // weight cache model: tile resident 3 cycles after each wgt_start
    initial begin
        wgt_cached = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && wgt_start) begin
                @(posedge clk); #1 wgt_cached = 1'b0;
                repeat (2) @(posedge clk);
                #1 wgt_cached = 1'b1;
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents an event
    always @(negedge clk) begin
        if (!reset) begin
            in_stream = 1'b0;
        end else begin
            if (wgt_start) begin
                chk("wgt_start_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("wgt_col_base", wgt_col_base, e.base);
                    chk("wgt_tile_cols", wgt_tile_cols, e.cols);
                    chk("tile_idx", tile_idx, e.tidx);
                    chk("wgt_matrix_row", wgt_matrix_row, e.row);
                end
            end
            if (out_valid && out_ready && in_stream) begin
                chk("beat_expected", 32'(bq.size() != 0), 32'd1);
                if (bq.size() != 0) begin
                    bexp_t b;
                    b = bq.pop_front();
                    chk("tile_last", tile_last, b.tl);
                    chk("out_last", out_last, b.ol);
                    if (b.ol) last_ol_cyc = cyc;
                    if (b.endf) in_stream = 1'b0;
                end
            end else begin
                chk("last_flags_idle", {tile_last, out_last}, 32'd0);
            end
            if (img_start) in_stream = 1'b1;
            if (done) begin
                chk("done_expected", 32'(dq.size() != 0), 32'd1);
                chk("busy_at_done", busy, 32'd0);
                if (dq.size() != 0) begin
                    logic e_err;
                    e_err = dq.pop_front();
                    chk("cfg_err_at_done", cfg_err, e_err);
                    if (!e_err) chk("final_beat_to_done", cyc - last_ol_cyc, 32'd1);
                end
            end
        end
    end

    task automatic push_layer(input int col, input int row, input int rows);
        int nt;
        nt = (col + 7) / 8;
        for (int t = 0; t < nt; t++) begin
            wexp_t w;
            w.base = 16'(8 * t);
            w.cols = 16'((col - 8 * t) > 8 ? 8 : (col - 8 * t));
            w.tidx = 8'(t);
            w.row  = 16'(row);
            wq.push_back(w);
            for (int b = 0; b < rows; b++) begin
                bexp_t e;
                e.tl   = (b == rows - 1);
                e.ol   = (b == rows - 1) && (t == nt - 1);
                e.endf = (b == rows - 1);
                bq.push_back(e);
            end
        end
        dq.push_back(1'b0);
    endtask

    // start pulse in cycle s; returns 1 ns into cycle s+1 with cfg scrambled
    task automatic start_layer(input int col, input int row, input int rows);
        @(posedge clk); #1;
        cfg_matrix_col = 16'(col);
        cfg_matrix_row = 16'(row);
        cfg_out_rows   = 32'(rows);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_matrix_col = 16'hABCD;
        cfg_matrix_row = 16'h1234;
        cfg_out_rows   = 32'h77;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < max);
        chk("done_seen", done, 32'd1);
        @(posedge clk);
    endtask

    task automatic wait_wq_empty(input int max);
        int n;
        n = 0;
        while (wq.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        chk("wgt_requests_issued", 32'(wq.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_matrix_row = '0;
        cfg_matrix_col = '0;
        cfg_out_rows   = '0;
        out_valid = 1'b1;

        #3;
        chk("rst_busy_done_err", {busy, done, cfg_err, wgt_start, img_start}, 32'd0);
        chk("rst_flags", {tile_last, out_last}, 32'd0);
        chk("rst_tile_idx", tile_idx, 32'd0);
        chk("rst_col_base", wgt_col_base, 32'd0);
        chk("rst_tile_cols", wgt_tile_cols, 32'd0);
        chk("rst_matrix_row", wgt_matrix_row, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // three tiles 8/8/4, five beats each
        push_layer(20, 288, 5);
        start_layer(20, 288, 5);
        @(negedge clk);
        chk("start_to_wgt_start", wgt_start, 32'd1);
        wait_done(200);
`ifdef SCHED_PERF_CNT_EN
        // per tile: WSTART 1 + WWAIT 3 + ISTART 1 + STREAM 5 = 10 busy cycles
        repeat (3) @(posedge clk);
        chk("perf_stall_cycles", perf_stall_cycles, 32'd9);
        chk("perf_busy_cycles", perf_busy_cycles, 32'd30);
`endif

        // four full tiles with ready toggling
        ready_mode = 1'b1;
        push_layer(32, 100, 4);
        start_layer(32, 100, 4);
        wait_done(400);
        ready_mode = 1'b0;

        // zero out_rows: straight to DONE with cfg_err
        dq.push_back(1'b1);
        start_layer(8, 288, 0);
        wait_done(2);
        @(negedge clk);
        chk("cfg_err_sticky", cfg_err, 32'd1);
        push_layer(8, 4, 2);
        start_layer(8, 4, 2);
        @(negedge clk);
        chk("cfg_err_cleared", cfg_err, 32'd0);
        wait_done(100);

        // 2049 columns -> 257 tiles, beyond the tile index range
        dq.push_back(1'b1);
        start_layer(2049, 4, 2);
        wait_done(2);

        // abort in WWAIT of tile 1
        push_layer(12, 9, 3);
        repeat (3) void'(bq.pop_back());
        void'(dq.pop_back());
        start_layer(12, 9, 3);
        wait_wq_empty(200);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_wwait_busy", busy, 32'd0);
        chk("abort_wwait_tile_idx", tile_idx, 32'd0);
        chk("abort_wwait_col_base", wgt_col_base, 32'd0);
        repeat (6) @(negedge clk);
        push_layer(12, 9, 3);
        start_layer(12, 9, 3);
        wait_done(200);

        // abort on the final beat of the layer
        push_layer(20, 288, 5);
        bq[bq.size() - 1] = '{tl: 1'b0, ol: 1'b0, endf: 1'b1};
        void'(dq.pop_back());
        start_layer(20, 288, 5);
        wait_wq_empty(200);
        repeat (8) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_final_busy", busy, 32'd0);
        repeat (5) @(negedge clk);

        // start repulsed during STREAM
        push_layer(16, 50, 6);
        start_layer(16, 50, 6);
        repeat (6) @(posedge clk);
        #1;
        cfg_matrix_col = 16'd8;
        cfg_matrix_row = 16'd1;
        cfg_out_rows   = 32'd1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("restart_busy", busy, 32'd1);
        chk("restart_tile_idx", tile_idx, 32'd0);
        chk("restart_matrix_row", wgt_matrix_row, 32'd50);
        chk("restart_tile_cols", wgt_tile_cols, 32'd8);
        wait_done(200);

        // asynchronous reset mid-STREAM
        push_layer(8, 7, 10);
        start_layer(8, 7, 10);
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_busy", busy, 32'd0);
        chk("async_rst_tile_cols", wgt_tile_cols, 32'd0);
        chk("async_rst_matrix_row", wgt_matrix_row, 32'd0);
        bq.delete();
        dq.delete();
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", busy, 32'd0);
        end

        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("bq_drained", 32'(bq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
